// File: rtl/myproject_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, NUM_STAGE slots, post-product shift and valid/ready flow control.
// Optional clamp of the shifted product to the signed dout range when MUL_PIPE_SAT_EN is defined.
module myproject_mul_pipe #(
    parameter int DIN0_WIDTH  = 12,
    parameter int DIN1_WIDTH  = 7,
    parameter int DOUT_WIDTH  = 18,
    parameter bit DIN0_SIGNED = 1'b1,
    parameter bit DIN1_SIGNED = 1'b0,
    parameter int NUM_STAGE   = 2,
    parameter int SHIFT       = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int EW = (PW > DOUT_WIDTH) ? PW : DOUT_WIDTH;

`ifdef MUL_PIPE_SAT_EN
    localparam logic signed [EW-1:0] SAT_MAX = EW'({1'b0, {(DOUT_WIDTH-1){1'b1}}});
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    function automatic logic signed [PW-1:0] mul_ext(
        input logic [DIN0_WIDTH-1:0] a,
        input logic [DIN1_WIDTH-1:0] b
    );
        logic signed [DIN0_WIDTH:0] a_x;
        logic signed [DIN1_WIDTH:0] b_x;
        a_x = {(DIN0_SIGNED ? a[DIN0_WIDTH-1] : 1'b0), a};
        b_x = {(DIN1_SIGNED ? b[DIN1_WIDTH-1] : 1'b0), b};
        return PW'(a_x) * PW'(b_x);
    endfunction

    // Arithmetic shift (floor), then wrap or clamp into the output width.
    function automatic logic [DOUT_WIDTH-1:0] size_out(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] q;
        logic signed [EW-1:0] qe;
        q  = p >>> SHIFT;
        qe = EW'(q);
`ifdef MUL_PIPE_SAT_EN
        if (qe > SAT_MAX) begin
            return {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end else if (qe < SAT_MIN) begin
            return {1'b1, {(DOUT_WIDTH-1){1'b0}}};
        end else begin
            return qe[DOUT_WIDTH-1:0];
        end
`else
        return qe[DOUT_WIDTH-1:0];
`endif
    endfunction

    logic [NUM_STAGE-1:0]  v_q;
    logic [NUM_STAGE-1:0]  load_s;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic signed [PW-1:0]  prod_s;
    logic signed [PW-1:0]  fin_src_s;
    logic                  fin_vld_s;

    assign prod_s = mul_ext(din0, din1);

    // A slot may load when it is empty or its content moves on this cycle.
    always_comb begin
        logic nxt;
        load_s = '0;
        nxt    = out_ready;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            load_s[k] = !v_q[k] || nxt;
            nxt       = load_s[k];
        end
    end

    assign in_ready  = load_s[0] && !ap_rst;
    assign out_valid = v_q[NUM_STAGE-1];
    assign dout      = dout_q;

    // Valid bits march forward; empty slots are refilled so bubbles collapse.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            v_q <= '0;
        end else begin
            if (load_s[0]) begin
                v_q[0] <= in_valid;
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (load_s[k]) begin
                    v_q[k] <= v_q[k-1];
                end
            end
        end
    end

    if (NUM_STAGE > 1) begin : g_mid
        logic signed [PW-1:0] pd_q [NUM_STAGE-1];

        // Product slots carry no reset; their contents only matter when valid.
        always_ff @(posedge ap_clk) begin
            if (load_s[0]) begin
                pd_q[0] <= prod_s;
            end
            for (int k = 1; k < NUM_STAGE - 1; k++) begin
                if (load_s[k]) begin
                    pd_q[k] <= pd_q[k-1];
                end
            end
        end

        assign fin_src_s = pd_q[NUM_STAGE-2];
        assign fin_vld_s = v_q[NUM_STAGE-2];
    end else begin : g_one
        assign fin_src_s = prod_s;
        assign fin_vld_s = in_valid;
    end

    // Output slot only captures real results so dout stays 0 after reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dout_q <= '0;
        end else if (load_s[NUM_STAGE-1] && fin_vld_s) begin
            dout_q <= size_out(fin_src_s);
        end
    end

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Directed bench: a default instance and a SHIFT=4 / 3-stage instance share the input side.
module tb_myproject_mul_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic [11:0] din0;
    logic [6:0]  din1;
    logic        in_ready0, out_valid0, out_ready0;
    logic [17:0] dout0;
    logic        in_ready1, out_valid1;
    logic        out_ready1;
    logic [17:0] dout1;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    myproject_mul_pipe u_dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .din0(din0), .din1(din1),
        .out_valid(out_valid0), .out_ready(out_ready0), .dout(dout0)
    );

    myproject_mul_pipe #(.NUM_STAGE(3), .SHIFT(4)) u_sh (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready1),
        .din0(din0), .din1(din1),
        .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1)
    );

    typedef struct {
        logic [11:0] a;
        logic [6:0]  b;
        logic [17:0] e0;
        logic [17:0] e1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input string nm);
        int lat0 = 0;
        int lat1 = 0;
        @(negedge ap_clk);
        din0     = t.a;
        din1     = t.b;
        in_valid = 1'b1;
        #1;
        check({nm, "_in_ready"}, 32'(in_ready0 & in_ready1), 32'd1);
        for (int c = 1; c <= 10 && (lat0 == 0 || lat1 == 0); c++) begin
            @(negedge ap_clk);
            if (c == 1) in_valid = 1'b0;
            if (out_valid0 && lat0 == 0) begin
                lat0 = c;
                check({nm, "_dout"}, 32'(dout0), 32'(t.e0));
            end
            if (out_valid1 && lat1 == 0) begin
                lat1 = c;
                check({nm, "_dout_sh"}, 32'(dout1), 32'(t.e1));
            end
        end
        check({nm, "_lat"}, 32'(lat0), 32'd2);
        check({nm, "_lat_sh"}, 32'(lat1), 32'd3);
    endtask

    initial begin
        int   k;
        int   acc;
        int   nxt;
        vec_t r;

        vecs[0] = '{12'd100, 7'd5,   18'h001F4, 18'h0001F};
        vecs[1] = '{12'hFFD, 7'd127, 18'h3FE83, 18'h3FFE8};
`ifdef MUL_PIPE_SAT_EN
        vecs[2] = '{12'h800, 7'd127, 18'h20000, 18'h3C080};
        vecs[3] = '{12'h7FF, 7'd127, 18'h1FFFF, 18'h03F78};
`else
        vecs[2] = '{12'h800, 7'd127, 18'h00800, 18'h3C080};
        vecs[3] = '{12'h7FF, 7'd127, 18'h3F781, 18'h03F78};
`endif
        vecs[4] = '{12'd0,   7'd0,   18'h00000, 18'h00000};
        vecs[5] = '{12'hFFF, 7'd1,   18'h3FFFF, 18'h3FFFF};
        vecs[6] = '{12'h800, 7'd1,   18'h3F800, 18'h3FF80};

        ap_rst = 1'b1; in_valid = 1'b0; din0 = 12'd0; din1 = 7'd0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        repeat (3) @(negedge ap_clk);
        check("rst_out_valid", 32'(out_valid0 | out_valid1), 32'd0);
        check("rst_in_ready", 32'(in_ready0 | in_ready1), 32'd0);
        check("rst_dout", 32'(dout0 | dout1), 32'd0);
        ap_rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready0), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: four stalled cycles while streaming (k,1)
        out_ready0 = 1'b0;
        k = 1; acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge ap_clk);
            din0 = 12'(k); din1 = 7'd1; in_valid = 1'b1;
            #1;
            if (c >= 2) begin
                check("stall_out_valid", 32'(out_valid0), 32'd1);
                check("stall_dout", 32'(dout0), 32'd1);
            end
            if (in_ready0) begin
                acc++; k++;
            end
        end
        check("stall_accepts", 32'(acc), 32'd2);
        check("stall_in_ready", 32'(in_ready0), 32'd0);
        nxt = 1;
        for (int c = 0; c < 30 && nxt <= 6; c++) begin
            @(negedge ap_clk);
            out_ready0 = 1'b1;
            if (k <= 6) begin
                din0 = 12'(k); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid0) begin
                check($sformatf("bp_out%0d", nxt), 32'(dout0), 32'(nxt));
                nxt++;
            end
            if (in_valid && in_ready0) k++;
        end
        check("bp_count", 32'(nxt), 32'd7);
        @(negedge ap_clk);
        in_valid = 1'b0;
        #1;
        check("bp_no_extra", 32'(out_valid0), 32'd0);
        repeat (4) @(negedge ap_clk);

        // Reset with two results in flight
        @(negedge ap_clk);
        din0 = 12'd3; din1 = 7'd3; in_valid = 1'b1;
        @(negedge ap_clk);
        din0 = 12'd4; din1 = 7'd4;
        @(negedge ap_clk);
        in_valid = 1'b0;
        ap_rst   = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready0), 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid0 | out_valid1), 32'd0);
        check("midrst_dout", 32'(dout0 | dout1), 32'd0);
        check("midrst_in_ready_after", 32'(in_ready0), 32'd1);
        @(negedge ap_clk);
        check("midrst_no_partial", 32'(out_valid0 | out_valid1), 32'd0);
        r = '{12'd7, 7'd7, 18'd49, 18'd3};
        run_vec(r, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
